can_frame_transmitter: RTL

- Serializer for classic CAN 2.0 data and remote frames. It is the transmit-side counterpart of the frame receiver chain.
- Latches one frame request and drives canTX one bit per bit time, on a one-cycle txPoint strobe.
- Inserts stuff bits and computes CRC-15.
- At each samplePoint, monitors canRX for arbitration loss, bit errors and ACK.
- Error-frame generation and retransmission are out of scope and are handled by the upstream controller.

---
 rtl/can_frame_transmitter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/can_frame_transmitter.sv
// rtl/can_frame_transmitter.sv - CAN 2.0 frame serializer with bit stuffing, CRC-15, arbitration/bit/ACK monitoring
// Define CAN_TX_EXTENDED_EN to enable 29-bit extended identifier frames.
module can_frame_transmitter #(
  parameter int IFS_BITS    = 3,
  parameter int STUFF_LIMIT = 5
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_tx_point,
  input  logic        i_sample_point,
  input  logic        i_can_rx,
  input  logic        i_start,
  input  logic [28:0] i_id,
  input  logic        i_ide,
  input  logic        i_rtr,
  input  logic [3:0]  i_dlc,
  input  logic [63:0] i_data,
  output logic        o_can_tx,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_arb_lost,
  output logic        o_bit_error,
  output logic        o_ack_error
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SOF      = 4'd1;
  localparam logic [3:0] S_ARB      = 4'd2;
  localparam logic [3:0] S_CTRL     = 4'd3;
  localparam logic [3:0] S_DATA     = 4'd4;
  localparam logic [3:0] S_CRC      = 4'd5;
  localparam logic [3:0] S_CRC_DEL  = 4'd6;
  localparam logic [3:0] S_ACK_SLOT = 4'd7;
  localparam logic [3:0] S_ACK_DEL  = 4'd8;
  localparam logic [3:0] S_EOF      = 4'd9;
  localparam logic [3:0] S_IFS      = 4'd10;

  logic [3:0]  r_state;
  logic [6:0]  r_cnt;
  logic [31:0] r_arb;
  logic [5:0]  r_arb_last;
  logic [5:0]  r_ctrl;
  logic [63:0] r_data;
  logic [6:0]  r_data_len;
  logic [14:0] r_crc;
  logic [3:0]  r_stuff_cnt;
  logic        r_last_bit;
  logic        r_tx;
  logic        r_armed;
  logic        r_tx_arb;
  logic        r_tx_ack;
  logic        r_tx_final;
  logic        r_done;
  logic        r_arb_lost;
  logic        r_bit_error;
  logic        r_ack_error;

  logic        w_ext;
  logic [31:0] w_arb_vec;
  logic [3:0]  w_bytes;
  logic [6:0]  w_data_len;
  logic        w_field_bit;
  logic        w_field_last;
  logic [3:0]  w_next_state;
  logic        w_in_stuff;
  logic        w_stuff_now;
  logic        w_crc_fb;
  logic [14:0] w_crc_next;

`ifdef CAN_TX_EXTENDED_EN
  assign w_ext     = i_ide;
  assign w_arb_vec = w_ext ? {i_id[28:18], 1'b1, 1'b1, i_id[17:0], i_rtr}
                           : {i_id[10:0], i_rtr, 20'd0};
`else
  logic w_unused;
  assign w_unused  = ^{i_ide, i_id[28:11]};
  assign w_ext     = 1'b0;
  assign w_arb_vec = {i_id[10:0], i_rtr, 20'd0};
`endif

  assign w_bytes    = (i_dlc > 4'd8) ? 4'd8 : i_dlc;
  assign w_data_len = i_rtr ? 7'd0 : {w_bytes, 3'b000};

  // Field bit to send next, whether it closes its field, and the following state.
  always_comb begin
    w_field_bit  = 1'b1;
    w_field_last = 1'b1;
    w_next_state = r_state;
    case (r_state)
      S_SOF: begin
        w_field_bit  = 1'b0;
        w_next_state = S_ARB;
      end
      S_ARB: begin
        w_field_bit  = r_arb[31];
        w_field_last = (r_cnt == {1'b0, r_arb_last});
        w_next_state = S_CTRL;
      end
      S_CTRL: begin
        w_field_bit  = r_ctrl[5];
        w_field_last = (r_cnt == 7'd5);
        w_next_state = (r_data_len == 7'd0) ? S_CRC : S_DATA;
      end
      S_DATA: begin
        w_field_bit  = r_data[63];
        w_field_last = (r_cnt == r_data_len - 7'd1);
        w_next_state = S_CRC;
      end
      S_CRC: begin
        w_field_bit  = r_crc[14];
        w_field_last = (r_cnt == 7'd14);
        w_next_state = S_CRC_DEL;
      end
      S_CRC_DEL:  w_next_state = S_ACK_SLOT;
      S_ACK_SLOT: w_next_state = S_ACK_DEL;
      S_ACK_DEL:  w_next_state = S_EOF;
      S_EOF: begin
        w_field_last = (r_cnt == 7'd6);
        w_next_state = S_IFS;
      end
      S_IFS: begin
        w_field_last = (r_cnt == 7'(IFS_BITS - 1));
        w_next_state = S_IFS;
      end
      default: ;
    endcase
  end

  // CRC_DEL is included so a stuff bit owed after the last CRC bit still goes out.
  assign w_in_stuff  = (r_state >= S_SOF) && (r_state <= S_CRC_DEL);
  assign w_stuff_now = w_in_stuff && (r_stuff_cnt == 4'(STUFF_LIMIT));
  assign w_crc_fb    = w_field_bit ^ r_crc[14];
  assign w_crc_next  = {r_crc[13:0], 1'b0} ^ (w_crc_fb ? 15'h4599 : 15'h0000);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 7'd0;
      r_arb       <= 32'd0;
      r_arb_last  <= 6'd0;
      r_ctrl      <= 6'd0;
      r_data      <= 64'd0;
      r_data_len  <= 7'd0;
      r_crc       <= 15'd0;
      r_stuff_cnt <= 4'd0;
      r_last_bit  <= 1'b1;
      r_tx        <= 1'b1;
      r_armed     <= 1'b0;
      r_tx_arb    <= 1'b0;
      r_tx_ack    <= 1'b0;
      r_tx_final  <= 1'b0;
      r_done      <= 1'b0;
      r_arb_lost  <= 1'b0;
      r_bit_error <= 1'b0;
      r_ack_error <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_arb_lost  <= 1'b0;
      r_bit_error <= 1'b0;
      r_ack_error <= 1'b0;
      if (r_state == S_IDLE) begin
        if (i_start) begin
          r_state     <= S_SOF;
          r_cnt       <= 7'd0;
          r_arb       <= w_arb_vec;
          r_arb_last  <= w_ext ? 6'd31 : 6'd11;
          r_ctrl      <= {2'b00, i_dlc};
          r_data      <= i_data;
          r_data_len  <= w_data_len;
          r_crc       <= 15'd0;
          r_stuff_cnt <= 4'd0;
          r_armed     <= 1'b0;
        end
      end else if (i_tx_point) begin
        r_armed    <= 1'b1;
        r_tx_arb   <= (r_state == S_ARB);
        r_tx_ack   <= (r_state == S_ACK_SLOT);
        r_tx_final <= (r_state == S_IFS) && w_field_last;
        if (w_stuff_now) begin
          r_tx        <= ~r_last_bit;
          r_last_bit  <= ~r_last_bit;
          r_stuff_cnt <= 4'd1;
        end else begin
          r_tx <= w_field_bit;
          if (r_state <= S_CRC) begin
            r_stuff_cnt <= (r_stuff_cnt != 4'd0 && w_field_bit == r_last_bit) ?
                           r_stuff_cnt + 4'd1 : 4'd1;
            r_last_bit  <= w_field_bit;
          end else begin
            r_stuff_cnt <= 4'd0;
          end
          if (r_state <= S_DATA) r_crc <= w_crc_next;
          if (r_state == S_CRC)  r_crc <= {r_crc[13:0], 1'b0};
          if (r_state == S_ARB)  r_arb <= {r_arb[30:0], 1'b0};
          if (r_state == S_CTRL) r_ctrl <= {r_ctrl[4:0], 1'b0};
          if (r_state == S_DATA) r_data <= {r_data[62:0], 1'b0};
          if (w_field_last) begin
            if (r_state != S_IFS) begin
              r_state <= w_next_state;
              r_cnt   <= 7'd0;
            end
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
      end else if (i_sample_point && r_armed) begin
        r_armed <= 1'b0;
        if (r_tx_ack) begin
          if (i_can_rx) begin
            r_ack_error <= 1'b1;
            r_tx        <= 1'b1;
            r_state     <= S_IDLE;
          end
        end else if (i_can_rx != r_tx) begin
          // Recessive overwritten during arbitration is a lost contest, not an error.
          if (r_tx_arb && r_tx) r_arb_lost <= 1'b1;
          else                  r_bit_error <= 1'b1;
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end else if (r_tx_final) begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      end
    end
  end

  assign o_can_tx    = r_tx;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_arb_lost  = r_arb_lost;
  assign o_bit_error = r_bit_error;
  assign o_ack_error = r_ack_error;

endmodule
